ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 device-to-host receiver. Deserialises keyboard frames from the PS/2 pins
//  into ps2_key_pressed/ps2_out, which the pipelined processor consumes.
//  Sits between the board pins and the processor core, in the processor clock domain.
//  Owns synchronisation and glitch filtering of ps2_clock, plus framing, odd parity and timeout.
// PARAMETERS
//  SYNC_STAGES     2      flops on ps2_clock/ps2_data before any logic (>=2)
//  DEBOUNCE        4      cycles the synced ps2_clock must hold steady before the filtered clock follows
//  TIMEOUT_CYCLES  50000  max cycles between filtered falling edges inside a frame (~1 ms @ 50 MHz)
// PORTS
//  clock            in   1  system clock; all state on rising edge
//  reset            in   1  asynchronous, active-low reset
//  ps2_clock        in   1  raw PS/2 clock pin (async, idle high)
//  ps2_data         in   1  raw PS/2 data pin (async, idle high)
//  ps2_key_pressed  out  1  one-cycle strobe: new valid byte on ps2_out
//  ps2_out          out  8  last accepted byte; held until the next strobe
//  parity_err       out  1  one-cycle pulse: frame discarded for bad parity
//  frame_err        out  1  one-cycle pulse: frame discarded for stop=0 or timeout
//  rx_busy          out  1  high while state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; sync flops=1; filtered clk=1; bit count=0.
//   Timeout count=0. ps2_out=8'h00; ps2_key_pressed, parity_err, frame_err and rx_busy all 0.
//   Reset mid-frame drops the partial frame. Nothing is emitted for it.
//  Filter: filt_clk takes synced ps2_clock only after DEBOUNCE consecutive equal samples.
//   Shorter glitches are ignored.
//   A fall event is a 1->0 transition of filt_clk. ps2_data (synced) is sampled in the same cycle.
//  FSM (advances only on fall events, except timeout):
//   IDLE   : data=0 (start) -> DATA, bit count=0. Data=1 -> stay in IDLE, no error.
//   DATA   : shift the byte in LSB first. After the 8th bit -> PARITY.
//   PARITY : latch the parity bit -> STOP.
//   STOP   : always -> IDLE. If stop=1 and ^{byte,parity}==1: ps2_out<=byte, strobe.
//            Else if stop=1 (bad parity): parity_err pulse.
//            Else (stop=0): frame_err pulse. Stop=0 takes precedence over bad parity.
//  Latency: the strobe/error pulse is asserted in the cycle after the stop-bit fall event.
//   ps2_out updates in that same cycle.
//  Timeout: the counter clears on every fall event and counts in non-IDLE states.
//   At TIMEOUT_CYCLES-1 the FSM goes to IDLE with a frame_err pulse and no strobe.
//  A discarded frame never changes ps2_out.
//  Pulse outputs are mutually exclusive and never high for 2 consecutive cycles.
// CONFIGURATION
//  PS2_BREAK_FILTER_EN defined:
//   Valid byte 8'hF0 -> no strobe; set break_pending. The next valid byte clears it and is not strobed.
//   Valid byte 8'hE0 -> no strobe, and break_pending is unchanged.
//   ps2_out updates only for strobed bytes.
//   Only make codes reach the core. break_pending clears on reset.
//  Not defined: every valid byte, including F0 and E0, is strobed.
// TESTING
//  1 Frame 0x1C, parity 0, stop 1, 12.5 kHz clock -> one strobe, ps2_out=8'h1C, no errors.
//  2 Frame 0x1C with parity 1 -> parity_err pulse once, no strobe, ps2_out keeps its prior value.
//  3 Frame 0x29, parity 0, stop 0 -> frame_err pulse, no strobe, then state IDLE and rx_busy=0.
//  4 Stop ps2_clock after 4 data bits for > TIMEOUT_CYCLES -> one frame_err pulse, rx_busy=0.
//    A following valid 0x29 frame is then accepted.
//  5 Insert (DEBOUNCE-1)-cycle low glitches on ps2_clock during a 0x1C frame -> ps2_out=8'h1C, no errors.
//    Assert reset mid-frame -> outputs go to reset values immediately. The next frame is received cleanly.
//  6 Send F0,1C then 1C -> with PS2_BREAK_FILTER_EN: one strobe (the last 1C).
//    Without the macro: three strobes (F0,1C,1C).

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter on ps2_clock, 11-bit frame decode, odd parity, timeout.
// Latency: strobe/error pulse one cycle after the filtered falling edge of the stop bit (plus sync + DEBOUNCE).
// Backpressure: none; the core must take ps2_out on the strobe. Optional macro PS2_BREAK_FILTER_EN drops break codes.
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   data_s;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   filt_clk;
    logic                   filt_clk_d;
    logic                   fall;
    logic [TO_W-1:0]        to_cnt;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_q, shift_n;
    logic       par_q, par_n;
    logic [7:0] out_n;
    logic       key_n, perr_n, ferr_n;

`ifdef PS2_BREAK_FILTER_EN
    logic break_pending, brk_n;
`endif

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = dat_sync[SYNC_STAGES-1];
    assign fall   = filt_clk_d & ~filt_clk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // filt_clk moves only on the DEBOUNCE-th consecutive differing sample
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_cnt    <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s == filt_clk) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                deb_cnt  <= '0;
                filt_clk <= clk_s;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            ps2_out         <= 8'h00;
            ps2_key_pressed <= 1'b0;
            parity_err      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state           <= state_n;
            bit_cnt         <= bit_cnt_n;
            shift_q         <= shift_n;
            par_q           <= par_n;
            ps2_out         <= out_n;
            ps2_key_pressed <= key_n;
            parity_err      <= perr_n;
            frame_err       <= ferr_n;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            break_pending <= 1'b0;
        end else begin
            break_pending <= brk_n;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_q;
        par_n     = par_q;
        out_n     = ps2_out;
        key_n     = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_n     = break_pending;
`endif
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n = {data_s, shift_q[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    par_n   = data_s;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_s) begin
                        ferr_n = 1'b1;
                    end else if (^{shift_q, par_q}) begin
`ifdef PS2_BREAK_FILTER_EN
                        // F0 arms the filter; the byte after it is its break code and is swallowed
                        if (shift_q == 8'hF0) begin
                            brk_n = 1'b1;
                        end else if (shift_q != 8'hE0) begin
                            if (break_pending) begin
                                brk_n = 1'b0;
                            end else begin
                                out_n = shift_q;
                                key_n = 1'b1;
                            end
                        end
`else
                        out_n = shift_q;
                        key_n = 1'b1;
`endif
                    end else begin
                        perr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_MAX) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of whole frames plus hand sequences for
// timeout, clock glitches, mid-frame reset and the break-code sequence.
module tb_ps2_keyboard_rx;

    localparam int HP = 20;
    localparam int TO = 300;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    ps2_keyboard_rx #(
        .SYNC_STAGES   (2),
        .DEBOUNCE      (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_clock      (ps2_clock),
        .ps2_data       (ps2_data),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .rx_busy        (rx_busy)
    );

    always #5 clock = ~clock;

    int n_strobe = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_viol   = 0;
    bit prev_pulse = 1'b0;

    always @(negedge clock) begin
        int p;
        p = int'(ps2_key_pressed) + int'(parity_err) + int'(frame_err);
        if (ps2_key_pressed) n_strobe <= n_strobe + 1;
        if (parity_err)      n_perr   <= n_perr + 1;
        if (frame_err)       n_ferr   <= n_ferr + 1;
        if (p > 1 || (p > 0 && prev_pulse)) n_viol <= n_viol + 1;
        prev_pulse <= (p > 0);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cycles(8);
            ps2_clock = 1'b0;
            wait_cycles(3);
            ps2_clock = 1'b1;
            wait_cycles(HP - 11);
        end else begin
            wait_cycles(HP);
        end
        ps2_clock = 1'b0;
        wait_cycles(HP);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                              input bit glitch, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
        ps2_data = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         par_flip;
        bit         stop;
        int         exp_strobe;
        int         exp_perr;
        int         exp_ferr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[8];
    int s0, p0, f0;

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
        vecs[2] = '{8'h29, 1'b0, 1'b0, 0, 0, 1, 8'h1C};
        vecs[3] = '{8'h29, 1'b0, 1'b1, 1, 0, 0, 8'h29};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 0, 0, 1, 8'hFF};

        #12;
        check("reset_out",    int'(ps2_out), 0);
        check("reset_strobe", int'(ps2_key_pressed), 0);
        check("reset_perr",   int'(parity_err), 0);
        check("reset_ferr",   int'(frame_err), 0);
        check("reset_busy",   int'(rx_busy), 0);
        @(negedge clock);
        reset = 1'b1;
        wait_cycles(10);

        for (int v = 0; v < 8; v++) begin
            s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
            send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop, 1'b0, 11);
            wait_cycles(20);
            check($sformatf("vec%0d_strobe", v), n_strobe - s0, vecs[v].exp_strobe);
            check($sformatf("vec%0d_perr", v),   n_perr - p0,   vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v),   n_ferr - f0,   vecs[v].exp_ferr);
            check($sformatf("vec%0d_out", v),    int'(ps2_out), int'(vecs[v].exp_out));
            check($sformatf("vec%0d_busy", v),   int'(rx_busy), 0);
        end

        // timeout after start + 4 data bits
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 5);
        wait_cycles(10);
        check("to_busy_mid", int'(rx_busy), 1);
        wait_cycles(TO + 100);
        check("to_ferr",   n_ferr - f0,   1);
        check("to_strobe", n_strobe - s0, 0);
        check("to_perr",   n_perr - p0,   0);
        check("to_busy",   int'(rx_busy), 0);
        check("to_out",    int'(ps2_out), 8'hFF);
        s0 = n_strobe; f0 = n_ferr;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11);
        wait_cycles(20);
        check("after_to_strobe", n_strobe - s0, 1);
        check("after_to_ferr",   n_ferr - f0,   0);
        check("after_to_out",    int'(ps2_out), 8'h29);

        // short low glitches on ps2_clock
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11);
        wait_cycles(20);
        check("glitch_strobe", n_strobe - s0, 1);
        check("glitch_perr",   n_perr - p0,   0);
        check("glitch_ferr",   n_ferr - f0,   0);
        check("glitch_out",    int'(ps2_out), 8'h1C);

        // reset mid-frame
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 4);
        wait_cycles(5);
        check("mid_busy", int'(rx_busy), 1);
        reset = 1'b0;
        #1;
        check("rst_async_out",  int'(ps2_out), 0);
        check("rst_async_busy", int'(rx_busy), 0);
        @(negedge clock);
        reset = 1'b1;
        wait_cycles(HP);
        check("rst_no_emit", (n_strobe - s0) + (n_perr - p0) + (n_ferr - f0), 0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        wait_cycles(20);
        check("post_rst_strobe", n_strobe - s0, 1);
        check("post_rst_out",    int'(ps2_out), 8'h1C);

        // F0,1C then 1C
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        wait_cycles(20);
`ifdef PS2_BREAK_FILTER_EN
        check("break_strobes", n_strobe - s0, 1);
`else
        check("break_strobes", n_strobe - s0, 3);
`endif
        check("break_errs", (n_perr - p0) + (n_ferr - f0), 0);
        check("break_out",  int'(ps2_out), 8'h1C);

        check("pulse_rules", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
